// File: rtl/branch_predictor_pkg.sv
// bp_pkg: shared branch-type and 2-bit counter definitions for the branch predictor.
package bp_pkg;

   typedef enum logic [1:0] {BR = 2'd0, JAL = 2'd1, CALL = 2'd2, RET = 2'd3} br_type_e;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
      return taken ? (c == ST ? ST : c + 2'd1) : (c == SNT ? SNT : c - 2'd1);
   endfunction

endpackage

// File: rtl/branch_predictor_ras.sv
// branch_ras: circular return-address stack; a push when full overwrites the oldest entry.
module branch_ras #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push,
   input  logic            pop,
   input  logic [XLEN-1:0] push_addr,
   output logic [XLEN-1:0] top,
   output logic            empty
);
   localparam int PW = RAS_DEPTH > 1 ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [XLEN-1:0] stack [RAS_DEPTH];
   logic [PW-1:0]   ptr, ptr_inc, ptr_dec;
   logic [CW-1:0]   cnt;

   // ptr is the next write slot; the top of stack sits just below it
   assign ptr_inc = ptr == PW'(RAS_DEPTH - 1) ? '0 : ptr + PW'(1);
   assign ptr_dec = ptr == '0 ? PW'(RAS_DEPTH - 1) : ptr - PW'(1);
   assign top     = stack[ptr_dec];
   assign empty   = cnt == '0;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ptr <= '0;
         cnt <= '0;
      end else if (push) begin
         ptr <= ptr_inc;
         if (cnt != CW'(RAS_DEPTH)) cnt <= cnt + CW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr_dec;
         cnt <= cnt - CW'(1);
      end

   always_ff @(posedge clk)
      if (push) stack[ptr] <= push_addr;

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit counters and a return-address stack, 1-cycle lookup.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BTB_ENTRIES = 16,
   parameter int RAS_DEPTH   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            pred_req,
   input  logic [XLEN-1:0] pred_pc,
   output logic            pred_valid,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic [1:0]      upd_type,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target
);
   localparam int IDX_W = $clog2(BTB_ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic [BTB_ENTRIES-1:0] v;
   logic [TAG_W-1:0]       tag [BTB_ENTRIES];
   logic [XLEN-1:0]        tgt [BTB_ENTRIES];
   br_type_e               ty  [BTB_ENTRIES];
   logic [1:0]             ctr [BTB_ENTRIES];

   logic [IDX_W-1:0] p_idx, u_idx;
   logic             p_hit, p_taken, u_hit, ras_empty;
   logic [XLEN-1:0]  p_tgt, ras_top;
   br_type_e         u_type;

   assign p_idx  = pred_pc[IDX_W+1:2];
   assign u_idx  = upd_pc[IDX_W+1:2];
   assign u_type = br_type_e'(upd_type);

   // prediction is computed from pre-update table/RAS state and registered
   always_comb begin
      p_hit   = v[p_idx] && tag[p_idx] == pred_pc[XLEN-1:IDX_W+2];
      p_taken = p_hit && (ty[p_idx] == BR ? ctr[p_idx][1] : 1'b1);
      p_tgt   = !p_taken ? pred_pc + XLEN'(4)
              : (ty[p_idx] == RET && !ras_empty) ? ras_top : tgt[p_idx];
      u_hit   = v[u_idx] && tag[u_idx] == upd_pc[XLEN-1:IDX_W+2];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) v <= '0;
      else if (upd_valid && !u_hit && upd_taken) v[u_idx] <= 1'b1;

   // entry payload is qualified by the valid bit, so it carries no reset
   always_ff @(posedge clk)
      if (upd_valid) begin
         if (u_hit) begin
            ctr[u_idx] <= ctr_step(ctr[u_idx], upd_taken);
            if (upd_taken) begin
               tgt[u_idx] <= upd_target;
               ty[u_idx]  <= u_type;
            end
         end else if (upd_taken) begin
            tag[u_idx] <= upd_pc[XLEN-1:IDX_W+2];
            tgt[u_idx] <= upd_target;
            ty[u_idx]  <= u_type;
            ctr[u_idx] <= WT;
         end
      end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {pred_valid, pred_hit, pred_taken, pred_target} <= '0;
      end else begin
         pred_valid <= pred_req;
         if (pred_req) begin
            pred_hit    <= p_hit;
            pred_taken  <= p_taken;
            pred_target <= p_tgt;
         end
      end

   branch_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (upd_valid && u_type == CALL),
      .pop       (upd_valid && u_type == RET),
      .push_addr (upd_pc + XLEN'(4)),
      .top       (ras_top),
      .empty     (ras_empty)
   );

endmodule
